awgn_stats_monitor: RTL and testbench

//  Receive-side consumer of the Box-Muller AWGN generator's x0/x1 sample pair.
//  On start, accumulates 2**LOG2_N valid sample pairs and reports per-channel

---
 rtl/awgn_stats_monitor_if.sv | 26 ++
 rtl/awgn_stats_monitor.sv | 109 ++++++++++
 tb/tb_awgn_stats_monitor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/awgn_stats_monitor_if.sv
// awgn_stats_monitor_if: sample-pair input and statistics result bundle
interface awgn_stats_monitor_if #(
    parameter int DATA_W = 16
);
    logic                       start;
    logic                       in_valid;
    logic signed [DATA_W-1:0]   x0;
    logic signed [DATA_W-1:0]   x1;
    logic                       busy;
    logic                       done;
    logic signed [DATA_W-1:0]   mean0;
    logic signed [DATA_W-1:0]   mean1;
    logic [2*DATA_W-1:0]        var0;
    logic [2*DATA_W-1:0]        var1;
    logic signed [2*DATA_W-1:0] xcorr;

    modport master (
        output start, in_valid, x0, x1,
        input  busy, done, mean0, mean1, var0, var1, xcorr
    );

    modport slave (
        input  start, in_valid, x0, x1,
        output busy, done, mean0, mean1, var0, var1, xcorr
    );
endinterface

// File: rtl/awgn_stats_monitor.sv
// awgn_stats_monitor: windowed mean, variance and cross-moment of x0/x1 noise pairs
module awgn_stats_monitor #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
) (
    input  logic                clk,
    input  logic                reset,
    awgn_stats_monitor_if.slave bus
);
    localparam int SW = DATA_W + LOG2_N;
    localparam int PW = 2 * DATA_W;
    localparam int QW = PW + LOG2_N;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACCUM = 3'd1;
    localparam logic [2:0] CALC1 = 3'd2;
    localparam logic [2:0] CALC2 = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [LOG2_N:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

    logic [2:0]               r_state;
    logic [LOG2_N:0]          r_cnt;
    logic signed [SW-1:0]     r_s0, r_s1;
    logic [QW-1:0]            r_q0, r_q1;
    logic signed [QW-1:0]     r_c;
    logic signed [DATA_W-1:0] r_m0, r_m1, r_mean0, r_mean1;
    logic [PW-1:0]            r_msq0, r_msq1, r_var0, r_var1;
    logic signed [PW-1:0]     r_xc, r_xcorr;
    logic signed [PW-1:0]     w_p00, w_p11, w_p01, w_mm0, w_mm1;
    logic [PW:0]              w_d0, w_d1;

    assign w_p00 = bus.x0 * bus.x0;
    assign w_p11 = bus.x1 * bus.x1;
    assign w_p01 = bus.x0 * bus.x1;
    assign w_mm0 = r_m0 * r_m0;
    assign w_mm1 = r_m1 * r_m1;
    // Extra top bit flags a negative variance caused by floor truncation of the mean.
    assign w_d0  = {1'b0, r_msq0} - {1'b0, w_mm0};
    assign w_d1  = {1'b0, r_msq1} - {1'b0, w_mm1};

    assign bus.busy  = r_state != IDLE;
    assign bus.done  = r_state == DONE;
    assign bus.mean0 = r_mean0;
    assign bus.mean1 = r_mean1;
    assign bus.var0  = r_var0;
    assign bus.var1  = r_var1;
    assign bus.xcorr = r_xcorr;

    // Window control: accumulate N valid pairs, then two register stages of post-processing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
            r_q0    <= '0;
            r_q1    <= '0;
            r_c     <= '0;
            r_m0    <= '0;
            r_m1    <= '0;
            r_msq0  <= '0;
            r_msq1  <= '0;
            r_xc    <= '0;
            r_mean0 <= '0;
            r_mean1 <= '0;
            r_var0  <= '0;
            r_var1  <= '0;
            r_xcorr <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= ACCUM;
                    r_cnt   <= '0;
                    r_s0    <= '0;
                    r_s1    <= '0;
                    r_q0    <= '0;
                    r_q1    <= '0;
                    r_c     <= '0;
                end
                ACCUM: if (r_cnt == N_CNT) begin
                    r_state <= CALC1;
                end else if (bus.in_valid) begin
                    r_cnt <= r_cnt + 1'b1;
                    r_s0  <= r_s0 + {{LOG2_N{bus.x0[DATA_W-1]}}, bus.x0};
                    r_s1  <= r_s1 + {{LOG2_N{bus.x1[DATA_W-1]}}, bus.x1};
                    r_q0  <= r_q0 + {{LOG2_N{1'b0}}, w_p00};
                    r_q1  <= r_q1 + {{LOG2_N{1'b0}}, w_p11};
                    r_c   <= r_c + {{LOG2_N{w_p01[PW-1]}}, w_p01};
                end
                CALC1: begin
                    r_state <= CALC2;
                    r_m0    <= r_s0[LOG2_N +: DATA_W];
                    r_m1    <= r_s1[LOG2_N +: DATA_W];
                    r_msq0  <= r_q0[LOG2_N +: PW];
                    r_msq1  <= r_q1[LOG2_N +: PW];
                    r_xc    <= r_c[LOG2_N +: PW];
                end
                CALC2: begin
                    r_state <= DONE;
                    r_mean0 <= r_m0;
                    r_mean1 <= r_m1;
                    r_var0  <= w_d0[PW] ? '0 : w_d0[PW-1:0];
                    r_var1  <= w_d1[PW] ? '0 : w_d1[PW-1:0];
                    r_xcorr <= r_xc;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_awgn_stats_monitor.sv
// tb_awgn_stats_monitor: randomized and directed windows checked against an arithmetic model
module tb_awgn_stats_monitor;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   sx0[N];
    int   sx1[N];

    always #5 clk = ~clk;

    awgn_stats_monitor_if #(.DATA_W(DW)) bus();

    awgn_stats_monitor #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint a);
        longint q;
        q = a / N;
        if ((a % N) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic run_window(input string tag, input int gap, input bit restart);
        longint s0 = 0, s1 = 0, q0 = 0, q1 = 0, c = 0, m0, m1, v0, v1, xc;
        for (int i = 0; i < N; i++) begin
            s0 += sx0[i];
            s1 += sx1[i];
            q0 += longint'(sx0[i]) * sx0[i];
            q1 += longint'(sx1[i]) * sx1[i];
            c  += longint'(sx0[i]) * sx1[i];
        end
        m0 = fdiv(s0);
        m1 = fdiv(s1);
        v0 = q0 / N - m0 * m0;
        v1 = q1 / N - m1 * m1;
        if (v0 < 0) v0 = 0;
        if (v1 < 0) v1 = 0;
        xc = fdiv(c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        bus.x0 = 16'sh1234;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        for (int i = 0; i < N; i++) begin
            if (gap == 1 && i > 0) begin
                bus.in_valid = 1'b0;
                bus.x0 = DW'($urandom);
                @(negedge clk);
            end
            if (gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.x1 = DW'($urandom);
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.x0 = DW'(sx0[i]);
            bus.x1 = DW'(sx1[i]);
            bus.start = restart && i == N / 2;
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.x0 = DW'($urandom);
        bus.x1 = DW'($urandom);
        @(posedge clk);
        #1 check({tag, "_early1"}, bus.done, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 check({tag, "_early2"}, bus.done, 0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_mean0"}, bus.mean0, m0);
        check({tag, "_mean1"}, bus.mean1, m1);
        check({tag, "_var0"}, bus.var0, v0);
        check({tag, "_var1"}, bus.var1, v1);
        check({tag, "_xcorr"}, bus.xcorr, xc);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_noreopen"}, bus.busy, 0);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.x0 = '0;
        bus.x1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mean0", bus.mean0, 0);
        check("rst_var1", bus.var1, 0);
        check("rst_xcorr", bus.xcorr, 0);
        reset = 1'b0;

        foreach (sx0[i]) begin sx0[i] = 100; sx1[i] = -50; end
        run_window("const", 0, 0);
        foreach (sx0[i]) begin sx0[i] = (i % 2) ? -1000 : 1000; sx1[i] = 0; end
        run_window("alt", 0, 0);
        foreach (sx0[i]) begin sx0[i] = -32768; sx1[i] = 32767; end
        run_window("extreme", 0, 0);
        foreach (sx0[i]) begin sx0[i] = 3; sx1[i] = 4; end
        run_window("toggle", 1, 1);
        foreach (sx0[i]) begin sx0[i] = i % 2; sx1[i] = 0; end
        run_window("clamp", 0, 0);
        for (int k = 0; k < 6; k++) begin
            foreach (sx0[i]) begin
                sx0[i] = (k < 3) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 150;
                sx1[i] = (k < 3) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 60)) + 20;
            end
            run_window($sformatf("rnd%0d", k), 2, k[0]);
        end

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.x0 = 16'sd7;
            bus.x1 = -16'sd9;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_mean0", bus.mean0, 0);
        check("mid_rst_mean1", bus.mean1, 0);
        check("mid_rst_var0", bus.var0, 0);
        check("mid_rst_xcorr", bus.xcorr, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("mid_rst_quiet", seen, 0);
        foreach (sx0[i]) begin sx0[i] = 7; sx1[i] = 0; end
        run_window("after_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
